bus_slave_regbank: RTL
======================

// Module: bus_slave_regbank
// PURPOSE
//  Generic bus slave responder: small register bank producing sN_rd_data / sN_rdy toward the
//  slave-side mux. Accepts a master request qualified by chip select and address strobe.
//  Inserts programmable wait states, then completes with a one-cycle rdy pulse.
//  Used as the default slave for scratch/config registers and as the template for peripheral slaves.
// PARAMETERS
//  DEPTH        16  number of 32-bit words (power of 2, 2..256)
//  IDX_W        4   log2(DEPTH); word index width
//  WAIT_CYCLES  1   wait states between accept and response (0..15)
// PORTS
//  clk       in   1   system clock, rising edge
//  reset_    in   1   asynchronous active-low reset
//  cs_       in   1   chip select from address decoder, active low (`ENABLE_)
//  as_       in   1   address strobe from master, active low (`ENABLE_)
//  rw        in   1   `READ / `WRITE
//  addr      in   30  word address; addr[IDX_W-1:0] selects the word, upper bits ignored
//  wr_data   in   32  write data
//  rd_data   out  32  read data to slave mux (registered)
//  rdy       out  1   transfer complete, active high, one cycle (registered)
//  be        in   4   byte enables, bit i = wr_data[8i+7:8i]; present only with BUS_SLAVE_BE_EN
// BEHAVIOUR
//  Reset (reset_ low, async): state IDLE, rdy=0, rd_data=0, wait count=0, all words=0.
//  FSM IDLE -> WAIT -> RESP -> IDLE (WAIT skipped when WAIT_CYCLES=0):
//  - IDLE: cs_==0 && as_==0 at rising edge -> latch rw, index, wr_data (and be); go WAIT
//    (count=WAIT_CYCLES-1), or RESP if WAIT_CYCLES=0. Otherwise stay IDLE.
//  - WAIT: count decrements each cycle; at count==0 go RESP. cs_ high during WAIT = abort:
//    back to IDLE, no write, rdy never asserted.
//  - RESP: rdy=1 for exactly this cycle; next state IDLE unconditionally.
//  Latency: request sampled at edge N -> rdy high in cycle N+1+WAIT_CYCLES.
//  Write commits on the edge entering RESP; read data is registered on that same edge, so
//  read-after-write to the same word returns the new value.
//  rd_data = addressed word during RESP of a read; 0 in every other cycle (incl. write RESP).
//  as_/cs_ asserted while in WAIT or RESP are ignored; next request earliest in the IDLE
//  cycle after RESP (min 2 + WAIT_CYCLES cycles per transfer). Master holds request until rdy.
//  Index wraps modulo DEPTH (addr bits >= IDX_W ignored); addr is word-granular, no
//  misalignment handling. rw values other than `WRITE treated as `READ.
//  Reset mid-transfer: immediate return to reset state, pending write discarded.
// CONFIGURATION
//  BUS_SLAVE_BE_EN defined: be port exists; write updates only bytes with be[i]=1 (be=0 ->
//  no change, still rdy). Undefined: no be port; every write updates all 32 bits.
//  Reads are unaffected by the macro.
// STRUCTURE
//  bus_head.v: state encodings BUS_SLV_IDLE/WAIT/RESP (2-bit), BUS_SLV_STATE_W,
//  plus existing `ENABLE_, `READ, `WRITE.
//  One sub-module: bus_slave_regbank_mem (DEPTH x 32 array, async-reset clear, synchronous
//  write with byte mask, registered read); FSM and wait counter stay in the top.
// TESTING
//  1 Reset: assert reset_ mid-WAIT -> rdy=0, rd_data=0 immediately; read word 3 after -> 0.
//  2 WAIT_CYCLES=1: write 0xDEADBEEF to addr 5, then read addr 5 -> rdy exactly 2 cycles after
//    each accept edge, one cycle wide, rd_data=0xDEADBEEF only in read RESP cycle.
//  3 WAIT_CYCLES=0 back-to-back: 4 writes held until rdy -> rdy every 2nd cycle, all committed.
//  4 Abort: WAIT_CYCLES=3, write 0x12345678 to addr 2, raise cs_ after 1 cycle -> no rdy;
//    read addr 2 -> 0x00000000.
//  5 Wrap: DEPTH=16, write 0xA5A5A5A5 to addr 0x13 -> read addr 3 returns 0xA5A5A5A5.
//  6 BUS_SLAVE_BE_EN: word 1=0x11223344, write 0xFFFFFFFF be=4'b0101 -> read 0x11FF33FF;
//    be=0 write -> rdy pulses, value unchanged.

Source files
------------

// File: rtl/bus_slave_regbank_pkg.sv
// rtl/bus_slave_regbank_pkg.sv - shared state encodings, bus polarities and byte-mask helper
package bus_slave_regbank_pkg;

    localparam int BUS_SLV_STATE_W = 2;

    typedef enum logic [BUS_SLV_STATE_W-1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_RESP = 2'd2
    } bus_slv_state_e;

    localparam logic ENABLE_ = 1'b0;
    localparam logic READ    = 1'b1;
    localparam logic WRITE   = 1'b0;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/bus_slave_regbank_mem.sv
// rtl/bus_slave_regbank_mem.sv - DEPTH x 32 word store, masked write, read data valid one cycle
module bus_slave_regbank_mem #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wr_data,
    input  logic [31:0]      wr_mask,
    output logic [31:0]      rd_data
);

    logic [31:0] words [DEPTH];

    // rd_data returns to zero on any edge without a read strobe, so it is only live in RESP.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                words[idx] <= (words[idx] & ~wr_mask) | (wr_data & wr_mask);
            end
            rd_data <= rd_en ? words[idx] : '0;
        end
    end

endmodule

// File: rtl/bus_slave_regbank.sv
// rtl/bus_slave_regbank.sv - wait-state bus slave register bank; BUS_SLAVE_BE_EN adds byte enables
module bus_slave_regbank
    import bus_slave_regbank_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int IDX_W       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
`ifdef BUS_SLAVE_BE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rd_data,
    output logic        rdy
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    bus_slv_state_e   state;
    logic [3:0]       wait_cnt;
    logic             lat_rw;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_data;
    logic             req;
    logic             abort;
    logic             go_resp;
    logic             cur_rw;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_data;
    logic [31:0]      cur_mask;
    logic             addr_unused;

    assign addr_unused = ^addr[29:IDX_W];

    assign req     = (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign abort   = (state == BUS_SLV_WAIT) && (cs_ != ENABLE_);
    assign go_resp = ((state == BUS_SLV_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == BUS_SLV_WAIT) && !abort && (wait_cnt == 4'd0));

    // With no wait states the commit happens on the accept edge, so take the bus directly.
    assign cur_rw   = (state == BUS_SLV_IDLE) ? rw : lat_rw;
    assign cur_idx  = (state == BUS_SLV_IDLE) ? addr[IDX_W-1:0] : lat_idx;
    assign cur_data = (state == BUS_SLV_IDLE) ? wr_data : lat_data;

`ifdef BUS_SLAVE_BE_EN
    logic [3:0] lat_be;
    assign cur_mask = be_to_mask((state == BUS_SLV_IDLE) ? be : lat_be);
`else
    assign cur_mask = '1;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= BUS_SLV_IDLE;
            wait_cnt <= '0;
            rdy      <= 1'b0;
            lat_rw   <= READ;
            lat_idx  <= '0;
            lat_data <= '0;
`ifdef BUS_SLAVE_BE_EN
            lat_be   <= '0;
`endif
        end else begin
            rdy <= go_resp;
            case (state)
                BUS_SLV_IDLE: begin
                    if (req) begin
                        lat_rw   <= rw;
                        lat_idx  <= addr[IDX_W-1:0];
                        lat_data <= wr_data;
`ifdef BUS_SLAVE_BE_EN
                        lat_be   <= be;
`endif
                        if (WAIT_CYCLES == 0) begin
                            state <= BUS_SLV_RESP;
                        end else begin
                            state    <= BUS_SLV_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                BUS_SLV_WAIT: begin
                    if (abort) begin
                        state <= BUS_SLV_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= BUS_SLV_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BUS_SLV_RESP: state <= BUS_SLV_IDLE;
                default:      state <= BUS_SLV_IDLE;
            endcase
        end
    end

    bus_slave_regbank_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .reset_  (reset_),
        .wr_en   (go_resp && (cur_rw == WRITE)),
        .rd_en   (go_resp && (cur_rw != WRITE)),
        .idx     (cur_idx),
        .wr_data (cur_data),
        .wr_mask (cur_mask),
        .rd_data (rd_data)
    );

endmodule
